// File: rtl/mmu_output_deskew.sv
// Purpose : re-align the skewed accumulator lanes of the systolic array into one
//           SIZE-lane result row per cycle, with valid strobe, row index and done pulse.
// Latency : row r of a job started on edge 0 is presented after edge FIRST_LAT+SIZE+r;
//           done pulses one cycle after the last row.
// Backpressure: none. The consumer must take every row as it is presented.
//
// Optional feature: define RELU_EN to clamp negative lanes to zero at the output
// register. Latency is the same with or without it.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        1-cycle job start pulse, same edge the array gets its first activation row
//   num_rows     number of result rows in the job, sampled on the start edge
//   acc_out      skewed accumulator lanes, lane j = [ACC_W*(j+1)-1 -: ACC_W]
//   out_vec      aligned result row, same lane packing as acc_out
//   out_valid    out_vec / out_index valid this cycle
//   out_index    0-based row number of out_vec
//   busy         job in progress (waiting for row 0 or streaming rows)
//   done         1-cycle pulse after the last row
module mmu_output_deskew #(
    parameter int SIZE      = 4,
    parameter int ACC_W     = 32,
    parameter int FIRST_LAT = 2,
    parameter int ROW_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_W-1:0]      num_rows,
    input  logic [ACC_W*SIZE-1:0] acc_out,
    output logic [ACC_W*SIZE-1:0] out_vec,
    output logic                  out_valid,
    output logic [ROW_W-1:0]      out_index,
    output logic                  busy,
    output logic                  done
);

    // Cycles spent in WAIT. The counter is loaded on the start edge and the FSM
    // enters STREAM on the edge where it reaches zero, so the first STREAM edge
    // (which registers row 0) lands on FIRST_LAT+SIZE.
    localparam int WAIT_INIT = FIRST_LAT + SIZE - 1;
    localparam int WCNT_W    = (WAIT_INIT < 2) ? 1 : $clog2(WAIT_INIT + 1);
    localparam int VEC_W     = ACC_W * SIZE;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // ------------------------------------------------------------------
    // Deskew delay lines
    // ------------------------------------------------------------------
    // Lane j arrives j cycles after lane 0, so it is delayed by SIZE-1-j
    // stages; lane SIZE-1 goes straight through. The stages shift every
    // cycle whatever the FSM is doing, so they are always primed by the
    // time a row becomes valid.
    logic [VEC_W-1:0] aligned;   // all lanes of one row, time-aligned
    logic [VEC_W-1:0] shaped;    // aligned row after optional ReLU

    for (genvar j = 0; j < SIZE; j++) begin : g_lane
        localparam int DEPTH = SIZE - 1 - j;

        logic [ACC_W-1:0] lane_in;
        logic [ACC_W-1:0] lane_al;

        assign lane_in = acc_out[ACC_W*(j+1)-1 -: ACC_W];

        if (DEPTH == 0) begin : g_thru
            assign lane_al = lane_in;
        end else begin : g_dly
            logic [ACC_W-1:0] dly_q [DEPTH];
            logic [ACC_W-1:0] dly_d [DEPTH];

            always_comb begin
                dly_d[0] = lane_in;
                for (int k = 1; k < DEPTH; k++) begin
                    dly_d[k] = dly_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < DEPTH; k++) begin
                        dly_q[k] <= dly_d[k];
                    end
                end
            end

            assign lane_al = dly_q[DEPTH-1];
        end

        assign aligned[ACC_W*(j+1)-1 -: ACC_W] = lane_al;

`ifdef RELU_EN
        // Negative accumulators (MSB set) become zero for the next layer.
        assign shaped[ACC_W*(j+1)-1 -: ACC_W] = lane_al[ACC_W-1] ? '0 : lane_al;
`else
        assign shaped[ACC_W*(j+1)-1 -: ACC_W] = lane_al;
`endif
    end

    // ------------------------------------------------------------------
    // Sequencing FSM and output register
    // ------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic [WCNT_W-1:0] wcnt_q,     wcnt_d;
    logic [ROW_W-1:0] num_rows_q,  num_rows_d;
    logic [ROW_W-1:0] row_cnt_q,   row_cnt_d;
    logic [VEC_W-1:0] out_vec_q,   out_vec_d;
    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_index_q, out_index_d;
    logic             done_q,      done_d;
    logic             last_row;

    // Compared one bit wider so num_rows = 2^ROW_W-1 cannot alias.
    assign last_row = ({1'b0, row_cnt_q} + 1'b1) == {1'b0, num_rows_q};

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        num_rows_d  = num_rows_q;
        row_cnt_d   = row_cnt_q;
        out_vec_d   = out_vec_q;     // vector and index hold between rows
        out_index_d = out_index_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_rows_d = num_rows;
                    row_cnt_d  = '0;
                    wcnt_d     = WCNT_W'(WAIT_INIT);
                    // An empty job skips straight to the done pulse.
                    state_d    = (num_rows == '0) ? ST_DONE : ST_WAIT;
                end
            end

            ST_WAIT: begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == WCNT_W'(1)) begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM: begin
                out_valid_d = 1'b1;
                out_vec_d   = shaped;
                out_index_d = row_cnt_q;
                row_cnt_d   = row_cnt_q + 1'b1;
                if (last_row) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // A start arriving here is dropped, not queued.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            num_rows_q  <= '0;
            row_cnt_q   <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            num_rows_q  <= num_rows_d;
            row_cnt_q   <= row_cnt_d;
            out_vec_q   <= out_vec_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            done_q      <= done_d;
        end
    end

    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign done      = done_q;
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_STREAM);

endmodule

// File: tb/tb_mmu_output_deskew.sv
// Purpose : self-checking bench for mmu_output_deskew (SIZE=4, FIRST_LAT=2).
// Latency : the model expects row r of a job started on edge s after edge s+6+r.
// Backpressure: none; the bench observes every cycle.
module tb_mmu_output_deskew;

    localparam int SIZE  = 4;
    localparam int ACC_W = 32;
    localparam int ROW_W = 16;
    localparam int VW    = SIZE * ACC_W;
    localparam int MAXC  = 4096;
    localparam int MAXR  = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic [VW-1:0]    acc_out;
    logic [VW-1:0]    out_vec;
    logic             out_valid;
    logic [ROW_W-1:0] out_index;
    logic             busy;
    logic             done;

    mmu_output_deskew #(.SIZE(SIZE), .ACC_W(ACC_W), .FIRST_LAT(2), .ROW_W(ROW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_rows  (num_rows),
        .acc_out   (acc_out),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_index (out_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;     // number of rising edges stepped so far
    bit checking = 1'b0;

    // Expected output state after each edge, filled in when a job is accepted.
    logic          exp_valid [MAXC];
    logic          exp_done  [MAXC];
    logic          exp_busy  [MAXC];
    logic [VW-1:0] exp_vec   [MAXC];
    logic [15:0]   exp_idx   [MAXC];

    int            free_edge = 0;   // first edge at which a start is accepted
    int            seq_s = -100;    // start edge of the job being driven
    int            seq_n = 0;
    logic [VW-1:0] seq_data [MAXR];
    logic [VW-1:0] nxt_data [MAXR];
    logic [31:0]   filler = 32'hDEAD;

    logic [VW-1:0] hold_vec = '0;
    logic [15:0]   hold_idx = '0;

    function automatic logic [VW-1:0] relu_row(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef RELU_EN
        for (int j = 0; j < SIZE; j++) begin
            if ($signed(v[32*j +: 32]) < 0) r[32*j +: 32] = 32'd0;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int e);
        for (int i = e; i < MAXC; i++) begin
            exp_valid[i] = 1'b0;
            exp_done[i]  = 1'b0;
            exp_busy[i]  = 1'b0;
            exp_vec[i]   = '0;
            exp_idx[i]   = '0;
        end
    endtask

    // One rising edge, then drive what acc_out presents after that edge:
    // lane j of row r appears after edge s+2+r+j.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        start = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
            int r;
            r = cyc - seq_s - 2 - j;
            if (r >= 0 && r < seq_n) acc_out[32*j +: 32] = seq_data[r][32*j +: 32];
            else                     acc_out[32*j +: 32] = filler;
        end
    endtask

    // Raise start for the next edge; if the model says the block is free,
    // record the job and its expected outputs.
    task automatic launch(input int n);
        int s;
        start    = 1'b1;
        num_rows = ROW_W'(n);
        s        = cyc + 1;
        if (s >= free_edge) begin
            seq_s = s;
            seq_n = n;
            for (int r = 0; r < MAXR; r++) seq_data[r] = nxt_data[r];
            if (n == 0) begin
                exp_done[s+1] = 1'b1;
                free_edge     = s + 2;
            end else begin
                for (int e = s; e <= s + 4 + n; e++) exp_busy[e] = 1'b1;
                for (int r = 0; r < n; r++) begin
                    exp_valid[s+6+r] = 1'b1;
                    exp_vec[s+6+r]   = relu_row(seq_data[r]);
                    exp_idx[s+6+r]   = 16'(r);
                end
                exp_done[s+6+n] = 1'b1;
                free_edge       = s + n + 7;
            end
        end
        step();
    endtask

    task automatic step_until(input int e);
        while (cyc < e) step();
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vec = '0;
            hold_idx = '0;
        end else if (checking && cyc < MAXC) begin
            if (exp_valid[cyc]) begin
                hold_vec = exp_vec[cyc];
                hold_idx = exp_idx[cyc];
            end
            chk("out_valid", VW'(out_valid), VW'(exp_valid[cyc]));
            chk("done",      VW'(done),      VW'(exp_done[cyc]));
            chk("busy",      VW'(busy),      VW'(exp_busy[cyc]));
            chk("out_vec",   out_vec,        hold_vec);
            chk("out_index", VW'(out_index), VW'(hold_idx));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int dn;
        clear_from(0);
        for (int r = 0; r < MAXR; r++) begin
            seq_data[r] = '0;
            nxt_data[r] = '0;
        end
        acc_out = {SIZE{filler}};

        // Reset state
        #23;
        chk("rst_valid", VW'(out_valid), '0);
        chk("rst_vec",   out_vec,        '0);
        chk("rst_index", VW'(out_index), '0);
        chk("rst_busy",  VW'(busy),      '0);
        chk("rst_done",  VW'(done),      '0);
        rst_n = 1'b1;
        step();
        checking = 1'b1;
        step();

        // Alignment, with a rejected start at edge s+4
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < SIZE; j++) nxt_data[r][32*j +: 32] = 32'(100*r + j);
        launch(3);
        s = cyc;
        step_until(s + 3);
        launch(7);
        step_until(s + 6);
        chk("c1_row0_vec", out_vec, {32'd3, 32'd2, 32'd1, 32'd0});
        chk("c1_row0_idx", VW'(out_index), VW'(0));
        step();
        chk("c1_row1_vec", out_vec, {32'd103, 32'd102, 32'd101, 32'd100});
        step();
        chk("c1_row2_idx", VW'(out_index), VW'(2));
        dn = 0;
        step();
        dn += int'(done);
        chk("c1_done_e9", VW'(done), VW'(1));

        // Back-to-back: start sampled while done is high
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < SIZE; j++) nxt_data[r][32*j +: 32] = 32'(500 + 10*r + j);
        launch(2);
        dn += int'(done);
        s = cyc;
        step_until(s + 6);
        chk("c6_valid", VW'(out_valid), VW'(1));
        chk("c6_idx0",  VW'(out_index), VW'(0));
        step_until(s + 10);
        chk("c3_one_done", VW'(dn), VW'(1));

        // Zero rows
        launch(0);
        s = cyc;
        step();
        chk("c2_done", VW'(done), VW'(1));
        step_until(s + 4);

        // Negative lane
        nxt_data[0] = {32'd7, 32'd6, 32'hFFFF_FFF6, 32'd4};
        launch(1);
        s = cyc;
        step_until(s + 6);
`ifdef RELU_EN
        chk("c5_relu_lane1", VW'(out_vec[63:32]), VW'(32'd0));
`else
        chk("c5_relu_lane1", VW'(out_vec[63:32]), VW'(32'hFFFF_FFF6));
`endif
        step_until(s + 9);

        // Reset between rows 0 and 1
        for (int r = 0; r < 3; r++) nxt_data[r] = {4{32'(900 + r)}};
        launch(3);
        s = cyc;
        step_until(s + 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c4_valid0", VW'(out_valid), '0);
        chk("c4_vec0",   out_vec,        '0);
        chk("c4_index0", VW'(out_index), '0);
        chk("c4_busy0",  VW'(busy),      '0);
        chk("c4_done0",  VW'(done),      '0);
        clear_from(cyc);
        free_edge = 0;
        seq_n     = 0;
        #4;
        rst_n = 1'b1;
        nxt_data[0] = {32'd44, 32'd33, 32'd22, 32'd11};
        launch(1);
        s = cyc;
        step_until(s + 6);
        chk("c4_after_valid", VW'(out_valid), VW'(1));
        chk("c4_after_idx",   VW'(out_index), VW'(0));
        chk("c4_after_vec",   out_vec, {32'd44, 32'd33, 32'd22, 32'd11});
        step_until(s + 9);

        // Randomised jobs, random gaps, random starts while busy
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int r = 0; r < MAXR; r++)
                    for (int j = 0; j < SIZE; j++)
                        nxt_data[r][32*j +: 32] = $urandom();
                filler = $urandom();
                launch(int'($urandom_range(0, 12)));
            end else begin
                step();
            end
        end
        step_until(cyc + 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
